// File: rtl/alu_pkg.sv
// Shared ALU op definitions for the issue queue and its neighbours.
// Opcode values and the decoded-op bundle carried between stages.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    localparam int RD_W_DEF = 5;

    typedef struct packed {
        logic [31:0]         SrcA;
        logic [31:0]         SrcB;
        logic [3:0]          ALUControl;
        logic [RD_W_DEF-1:0] Rd;
        logic                RegWrite;
    } alu_op_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Valid/ready handshake carrying one decoded ALU op.
// master drives valid and op; slave drives ready.
interface alu_issue_queue_if;
    import alu_pkg::*;

    logic    valid;
    logic    ready;
    alu_op_t op;

    modport master (output valid, output op, input ready);
    modport slave  (input valid, input op, output ready);

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Head/tail/count bookkeeping for a power-of-two circular queue.
// Flush and reset both collapse the queue to empty.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_req,
    input  logic          pop_req,
    output logic          push,
    output logic [AW-1:0] head,
    output logic [AW-1:0] tail,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic pop;

    // Full/empty come from count so head == tail stays unambiguous.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign push = push_req && !full && !flush && !rst;
    assign pop  = pop_req && !empty && !flush && !rst;

    // Pointer and occupancy update; pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order issue buffer between register read and the ALU.
// Head entry is presented registered-only; no in->out bypass.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RD_W  = RD_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    alu_issue_queue_if.slave             enq,
    alu_issue_queue_if.master            deq,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    alu_op_t        mem [DEPTH];
    alu_op_t        head_op;
    logic [RD_W-1:0] head_rd;
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic           push;
    logic           full;
    logic           empty;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push_req (enq.valid),
        .pop_req  (deq.ready),
        .push     (push),
        .head     (head),
        .tail     (tail),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // in_ready depends only on registered occupancy.
    assign enq.ready = !full;
    assign deq.valid = !empty;

    // Entry storage; left uncleared by reset since count masks it.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= enq.op;
    end

    assign head_op = mem[head];
    assign head_rd = head_op.Rd;

    // Head entry gated to zero (ADD, no writeback) when empty.
    always_comb begin
        deq.op = '0;
        if (!empty) begin
            deq.op.SrcA       = head_op.SrcA;
            deq.op.SrcB       = head_op.SrcB;
            deq.op.ALUControl = head_op.ALUControl;
            deq.op.Rd         = head_rd;
            deq.op.RegWrite   = head_op.RegWrite;
        end
    end

endmodule
